// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback-port arbiter.
package wb_pkg;
    localparam int REG_ADDR_W = 6;
    localparam int DATA_W     = 32;
    localparam logic [REG_ADDR_W-1:0] X0_ADDR = 6'h00;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wb_req_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus bundle: pipeline WB request, late-result push, register-file port.
// master = requester/register-file side, slave = the arbiter.
interface wb_arbiter_if;
    import wb_pkg::*;

    logic                  pipe_wb_en;
    logic [REG_ADDR_W-1:0] pipe_wb_addr;
    logic [DATA_W-1:0]     pipe_wb_data;
    logic                  pipe_hold;
    logic                  late_valid;
    logic                  late_ready;
    logic [REG_ADDR_W-1:0] late_addr;
    logic [DATA_W-1:0]     late_data;
    logic                  rf_wb_en;
    logic [REG_ADDR_W-1:0] rf_wb_addr;
    logic [DATA_W-1:0]     rf_wb_data;

    modport master (
        output pipe_wb_en, pipe_wb_addr, pipe_wb_data, late_valid, late_addr, late_data,
        input  pipe_hold, late_ready, rf_wb_en, rf_wb_addr, rf_wb_data
    );
    modport slave (
        input  pipe_wb_en, pipe_wb_addr, pipe_wb_data, late_valid, late_addr, late_data,
        output pipe_hold, late_ready, rf_wb_en, rf_wb_addr, rf_wb_data
    );
endinterface

// File: rtl/wb_fifo.sv
// Late-result FIFO. DEPTH must be a power of two so pointers wrap naturally.
// Push while full and pop while empty are ignored.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  wb_req_t                push_data,
    input  logic                   pop,
    output wb_req_t                head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    wb_req_t       mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // storage needs no reset; occupancy guards every read
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. buffered late results,
// with starvation-forced drains and a 64-entry pending scoreboard for hazards.
// Optional macro WB_BYPASS_EN: a late result may write the port in its arrival
// cycle when nothing else competes.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   bus_stall,
    wb_arbiter_if.slave            bus,
    input  logic                   issue_en,
    input  logic [REG_ADDR_W-1:0]  issue_addr,
    input  logic [REG_ADDR_W-1:0]  rs1_addr,
    input  logic [REG_ADDR_W-1:0]  rs2_addr,
    input  logic [REG_ADDR_W-1:0]  rd_addr,
    input  logic                   rd_we,
    output logic                   hazard_stall,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0]  cnt, cnt_nxt;
    logic [63:0]    pend, pend_nxt;
    wb_req_t        head, late_req;
    logic           full, empty, pop, push, bypass;
    logic           late_wr;
    logic           wb_en;
    wb_req_t        wb_req;

    assign late_req = '{addr: bus.late_addr, data: bus.late_data};
    assign push     = bus.late_valid && !full && !bypass;
    assign bus.late_ready = !full;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (late_req),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count)
    );

    // port select: stall > forced drain > pipeline > FIFO drain (> bypass)
    always_comb begin
        pop           = 1'b0;
        bypass        = 1'b0;
        late_wr       = 1'b0;
        wb_en         = 1'b0;
        wb_req        = '0;
        bus.pipe_hold = 1'b0;
        cnt_nxt       = cnt;
        if (bus_stall) begin
            cnt_nxt = cnt;
        end else if (cnt == CW'(STARVE_MAX) && !empty) begin
            pop           = 1'b1;
            wb_req        = head;
            wb_en         = (head.addr != X0_ADDR);
            late_wr       = wb_en;
            bus.pipe_hold = bus.pipe_wb_en;
            cnt_nxt       = '0;
        end else if (bus.pipe_wb_en) begin
            wb_req  = '{addr: bus.pipe_wb_addr, data: bus.pipe_wb_data};
            wb_en   = 1'b1;
            cnt_nxt = empty ? '0 : cnt + CW'(1);
        end else if (!empty) begin
            pop     = 1'b1;
            wb_req  = head;
            wb_en   = (head.addr != X0_ADDR);
            late_wr = wb_en;
            cnt_nxt = '0;
        end
`ifdef WB_BYPASS_EN
        else if (bus.late_valid && cnt < CW'(STARVE_MAX)) begin
            bypass  = 1'b1;
            wb_req  = late_req;
            wb_en   = (late_req.addr != X0_ADDR);
            late_wr = wb_en;
            cnt_nxt = '0;
        end
`endif
    end

    assign bus.rf_wb_en   = wb_en;
    assign bus.rf_wb_addr = wb_en ? wb_req.addr : '0;
    assign bus.rf_wb_data = wb_en ? wb_req.data : '0;

    // scoreboard update: clear on late write, then set on issue so set wins
    always_comb begin
        pend_nxt = pend;
        if (late_wr) pend_nxt[wb_req.addr] = 1'b0;
        if (issue_en && issue_addr != X0_ADDR) pend_nxt[issue_addr] = 1'b1;
    end

    // starvation counter and scoreboard registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            pend <= '0;
        end else begin
            cnt  <= cnt_nxt;
            pend <= pend_nxt;
        end
    end

    assign hazard_stall = pend[rs1_addr] | pend[rs2_addr] | (rd_we & pend[rd_addr]);
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter (DEPTH=4, STARVE_MAX=8). Inputs change 1 time
// unit after the rising edge; outputs are sampled on the falling edge.
module tb_wb_arbiter;
    import wb_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bus_stall = 1'b0;
    logic       issue_en = 1'b0;
    logic [5:0] issue_addr = '0;
    logic [5:0] rs1_addr = '0, rs2_addr = '0, rd_addr = '0;
    logic       rd_we = 1'b0;
    logic       hazard_stall;
    logic [2:0] fifo_count;

    int n_chk = 0;
    int n_err = 0;

    wb_arbiter_if bus ();

    wb_arbiter #(.DEPTH(4), .STARVE_MAX(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus_stall    (bus_stall),
        .bus          (bus.slave),
        .issue_en     (issue_en),
        .issue_addr   (issue_addr),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rd_addr      (rd_addr),
        .rd_we        (rd_we),
        .hazard_stall (hazard_stall),
        .fifo_count   (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nx();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        bus.pipe_wb_en = 1'b0; bus.pipe_wb_addr = '0; bus.pipe_wb_data = '0;
        bus.late_valid = 1'b0; bus.late_addr = '0; bus.late_data = '0;

        // reset state
        #3;
        chk("rst_rf_en", bus.rf_wb_en, 0);
        chk("rst_rf_addr", bus.rf_wb_addr, 0);
        chk("rst_rf_data", bus.rf_wb_data, 0);
        chk("rst_hold", bus.pipe_hold, 0);
        chk("rst_ready", bus.late_ready, 1);
        chk("rst_hazard", hazard_stall, 0);
        chk("rst_count", fifo_count, 0);
        nx(); nx();
        rst_n = 1'b1;
        nx();

        // issue to x5, then late result
        issue_en = 1'b1; issue_addr = 6'h05;
        nx();
        issue_en = 1'b0; rs1_addr = 6'h05;
        smp();
        chk("t1_hazard_pend", hazard_stall, 1);
        nx();
        bus.late_valid = 1'b1; bus.late_addr = 6'h05; bus.late_data = 32'hDEADBEEF;
        smp();
`ifdef WB_BYPASS_EN
        chk("t1_byp_en", bus.rf_wb_en, 1);
        chk("t1_byp_addr", bus.rf_wb_addr, 6'h05);
        chk("t1_byp_data", bus.rf_wb_data, 32'hDEADBEEF);
        chk("t1_byp_hazard", hazard_stall, 1);
        nx();
        bus.late_valid = 1'b0;
        smp();
        chk("t1_byp_hazard_clr", hazard_stall, 0);
        chk("t1_byp_count", fifo_count, 0);
`else
        chk("t1_push_en", bus.rf_wb_en, 0);
        chk("t1_push_hazard", hazard_stall, 1);
        nx();
        bus.late_valid = 1'b0;
        smp();
        chk("t1_wr_en", bus.rf_wb_en, 1);
        chk("t1_wr_addr", bus.rf_wb_addr, 6'h05);
        chk("t1_wr_data", bus.rf_wb_data, 32'hDEADBEEF);
        chk("t1_wr_hazard", hazard_stall, 1);
        nx();
        smp();
        chk("t1_hazard_clr", hazard_stall, 0);
        chk("t1_idle_en", bus.rf_wb_en, 0);
`endif
        rs1_addr = '0;
        nx();

        // starvation: one queued entry, pipeline busy 12 cycles
        bus.pipe_wb_en = 1'b1; bus.pipe_wb_addr = 6'h03; bus.pipe_wb_data = 32'h3333;
        bus.late_valid = 1'b1; bus.late_addr = 6'h07; bus.late_data = 32'h77;
        smp();
        chk("t2_a_addr", bus.rf_wb_addr, 6'h03);
        nx();
        bus.late_valid = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            smp();
            chk($sformatf("t2_addr_%0d", i), bus.rf_wb_addr, (i == 9) ? 6'h07 : 6'h03);
            chk($sformatf("t2_hold_%0d", i), bus.pipe_hold, (i == 9) ? 1 : 0);
            nx();
        end

        // fill to DEPTH with pipeline busy, fifth push waits for a pop
        for (int k = 0; k < 4; k++) begin
            bus.late_valid = 1'b1; bus.late_addr = 6'(6'h11 + k); bus.late_data = 32'hA0 + k;
            smp();
            chk($sformatf("t3_ready_%0d", k), bus.late_ready, 1);
            nx();
        end
        bus.late_addr = 6'h15; bus.late_data = 32'hA4;
        smp();
        chk("t3_full_ready", bus.late_ready, 0);
        chk("t3_full_count", fifo_count, 4);
        nx();
        bus.pipe_wb_en = 1'b0;
        smp();
        chk("t3_pop0_addr", bus.rf_wb_addr, 6'h11);
        chk("t3_pop0_ready", bus.late_ready, 0);
        nx();
        smp();
        chk("t3_pop1_addr", bus.rf_wb_addr, 6'h12);
        chk("t3_pop1_ready", bus.late_ready, 1);
        nx();
        bus.late_valid = 1'b0;
        for (int k = 2; k < 5; k++) begin
            smp();
            chk($sformatf("t3_pop%0d_addr", k), bus.rf_wb_addr, 6'(6'h11 + k));
            chk($sformatf("t3_pop%0d_data", k), bus.rf_wb_data, 32'hA0 + k);
            nx();
        end
        smp();
        chk("t3_empty", fifo_count, 0);
        nx();

        // bus_stall with two queued entries and pipeline requesting
        bus.pipe_wb_en = 1'b1;
        bus.late_valid = 1'b1; bus.late_addr = 6'h21; bus.late_data = 32'h21;
        nx();
        bus.late_addr = 6'h22; bus.late_data = 32'h22;
        nx();
        bus.late_valid = 1'b0; bus_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            smp();
            chk($sformatf("t4_stall_en_%0d", i), bus.rf_wb_en, 0);
            chk($sformatf("t4_stall_cnt_%0d", i), fifo_count, 2);
            nx();
        end
        bus_stall = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            smp();
            chk($sformatf("t4_hold_%0d", i), bus.pipe_hold, 0);
            nx();
        end
        smp();
        chk("t4_force_hold", bus.pipe_hold, 1);
        chk("t4_force_addr", bus.rf_wb_addr, 6'h21);
        nx();
        bus.pipe_wb_en = 1'b0;
        smp();
        chk("t4_drain_addr", bus.rf_wb_addr, 6'h22);
        chk("t4_drain_en", bus.rf_wb_en, 1);
        nx();

        // x0 is discarded, 6'h20 is a real register
        issue_en = 1'b1; issue_addr = 6'h20;
        nx();
        issue_addr = 6'h00;
        nx();
        issue_en = 1'b0; rs1_addr = 6'h00; rs2_addr = 6'h20;
        smp();
        chk("t5_hazard_fp", hazard_stall, 1);
        rs2_addr = 6'h00;
        #1;
        chk("t5_x0_not_pend", hazard_stall, 0);
        rs2_addr = 6'h20;
        nx();
        bus.late_valid = 1'b1; bus.late_addr = 6'h00; bus.late_data = 32'h5555;
`ifdef WB_BYPASS_EN
        smp();
        chk("t5_x0_en", bus.rf_wb_en, 0);
        nx();
        bus.late_addr = 6'h20; bus.late_data = 32'h2020;
        smp();
        chk("t5_fp_en", bus.rf_wb_en, 1);
        chk("t5_fp_addr", bus.rf_wb_addr, 6'h20);
        nx();
        bus.late_valid = 1'b0;
        smp();
        chk("t5_fp_clr", hazard_stall, 0);
`else
        nx();
        bus.late_addr = 6'h20; bus.late_data = 32'h2020;
        smp();
        chk("t5_x0_en", bus.rf_wb_en, 0);
        chk("t5_x0_addr", bus.rf_wb_addr, 0);
        nx();
        bus.late_valid = 1'b0;
        smp();
        chk("t5_fp_en", bus.rf_wb_en, 1);
        chk("t5_fp_addr", bus.rf_wb_addr, 6'h20);
        chk("t5_fp_data", bus.rf_wb_data, 32'h2020);
        chk("t5_fp_hazard", hazard_stall, 1);
        nx();
        smp();
        chk("t5_fp_clr", hazard_stall, 0);
`endif
        chk("t5_count", fifo_count, 0);
        rs2_addr = '0;
        nx();

        // asynchronous reset mid-operation
        bus.pipe_wb_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            issue_en = 1'b1; issue_addr = 6'(k + 1);
            bus.late_valid = 1'b1; bus.late_addr = 6'(k + 1); bus.late_data = 32'(k);
            nx();
        end
        issue_en = 1'b0; bus.late_valid = 1'b0;
        rs1_addr = 6'h01; rs2_addr = 6'h02; rd_addr = 6'h03; rd_we = 1'b1;
        smp();
        chk("t6_pre_count", fifo_count, 3);
        chk("t6_pre_hazard", hazard_stall, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_count", fifo_count, 0);
        chk("t6_rst_hazard", hazard_stall, 0);
        chk("t6_rst_ready", bus.late_ready, 1);
        bus.pipe_wb_en = 1'b0;
        nx();
        rst_n = 1'b1;
        rs1_addr = 6'h03; rs2_addr = 6'h00; rd_we = 1'b0;
        smp();
        chk("t6_post_hazard", hazard_stall, 0);
        chk("t6_post_en", bus.rf_wb_en, 0);
        nx();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
